// File: rtl/ctrl_sequencer.sv
// Registered multi-cycle control sequencer: one opcode per handshake, load stretching,
// branch bubbles, stall/flush. Define CTRL_SEQ_PERF_EN to add retired/stall_cycles counters.
module ctrl_sequencer #(
   parameter int MCODEBITS  = 3,
   parameter int OPWIDTH    = 3,
   parameter int MEM_LAT    = 2,
   parameter int BR_BUBBLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   input  logic [MCODEBITS-1:0] instr,
   output logic                 instr_ready,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 ctrl_valid,
   output logic                 RegDst,
   output logic                 Branch,
   output logic                 MemtoReg,
   output logic                 MemWrite,
   output logic                 ALUSrc,
   output logic                 RegWrite,
   output logic [OPWIDTH-1:0]   ALUOp,
   output logic                 illegal
`ifdef CTRL_SEQ_PERF_EN
   ,
   output logic [31:0]          retired,
   output logic [31:0]          stall_cycles
`endif
);

   localparam int CNT_MAX = (MEM_LAT > BR_BUBBLES) ? MEM_LAT : BR_BUBBLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BR_INIT = (BR_BUBBLES > 0) ? BR_BUBBLES - 1 : 0;

   typedef enum logic [1:0] {RUN, MEM_WAIT, BUBBLE} state_t;

   typedef struct packed {
      logic       cv;
      logic       br;
      logic       m2r;
      logic       mw;
      logic       src;
      logic       rw;
      logic [2:0] op;
   } ctrl_t;

   localparam ctrl_t NOP = '{cv: 1'b0, br: 1'b0, m2r: 1'b0, mw: 1'b0,
                             src: 1'b0, rw: 1'b0, op: 3'b111};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             ill_q, ill_d;
   logic             accept;
   logic             op_illegal;

   generate
      if (MCODEBITS > 3) begin : g_wide
         assign op_illegal = |instr[MCODEBITS-1:3];
      end else begin : g_narrow
         assign op_illegal = 1'b0;
      end
   endgenerate

   // Load strobes carry cv/rw = 0 here; the wait-state logic raises them on the final cycle.
   function automatic ctrl_t decode(input logic [2:0] op);
      ctrl_t d;
      d    = NOP;
      d.cv = 1'b1;
      case (op)
         3'b000: begin d.rw = 1'b1; d.op = 3'b000; end
         3'b001: begin d.rw = 1'b1; d.op = 3'b001; end
         3'b010: begin d.rw = 1'b1; d.op = 3'b010; end
         3'b011: begin d.m2r = 1'b1; d.cv = 1'b0; end
         3'b100: d.mw = 1'b1;
         3'b101: d.rw = 1'b1;
         3'b110: begin d.br = 1'b1; d.op = 3'b011; end
         default: begin d.src = 1'b1; d.rw = 1'b1; d.op = 3'b110; end
      endcase
      return d;
   endfunction

   assign instr_ready = (state_q == RUN) && !stall && !flush && !ill_q;
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      ill_d   = ill_q;
      if (flush) begin
         state_d = RUN;
         cnt_d   = '0;
         ctrl_d  = NOP;
      end else if (!stall) begin
         case (state_q)
            RUN: begin
               ctrl_d = NOP;
               if (accept) begin
                  if (op_illegal) begin
                     ill_d = 1'b1;
                  end else begin
                     ctrl_d = decode(instr[2:0]);
                     if (instr[2:0] == 3'b011) begin
                        state_d   = MEM_WAIT;
                        cnt_d     = CNT_W'(MEM_LAT - 1);
                        ctrl_d.rw = (MEM_LAT == 1);
                        ctrl_d.cv = (MEM_LAT == 1);
                     end else if (instr[2:0] == 3'b110 && BR_BUBBLES > 0) begin
                        state_d = BUBBLE;
                        cnt_d   = CNT_W'(BR_INIT);
                     end
                  end
               end
            end
            MEM_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = RUN;
                  ctrl_d  = NOP;
               end else begin
                  cnt_d      = cnt_q - CNT_W'(1);
                  ctrl_d     = decode(3'b011);
                  ctrl_d.rw  = (cnt_q == CNT_W'(1));
                  ctrl_d.cv  = (cnt_q == CNT_W'(1));
               end
            end
            BUBBLE: begin
               ctrl_d = NOP;
               // The branch strobe itself occupies the first BUBBLE cycle; bubbles count after it.
               if (!ctrl_q.br) begin
                  if (cnt_q == '0) state_d = RUN;
                  else             cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
               ctrl_d  = NOP;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ctrl_q  <= NOP;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         ill_q   <= ill_d;
      end
   end

   // Held strobes stay registered during stall but must not fire twice.
   assign ctrl_valid = ctrl_q.cv & ~stall;
   assign MemWrite   = ctrl_q.mw & ~stall;
   assign RegWrite   = ctrl_q.rw & ~stall;
   assign RegDst     = 1'b0;
   assign Branch     = ctrl_q.br;
   assign MemtoReg   = ctrl_q.m2r;
   assign ALUSrc     = ctrl_q.src;
   assign ALUOp      = OPWIDTH'(ctrl_q.op);
   assign illegal    = ill_q;

`ifdef CTRL_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         retired      <= '0;
         stall_cycles <= '0;
      end else begin
         if (ctrl_valid) retired      <= retired + 32'd1;
         if (stall)      stall_cycles <= stall_cycles + 32'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: vector table through a scoreboard queue plus
// hand sequences for stall restore, illegal opcodes and a MEM_LAT=1 / BR_BUBBLES=0 instance.
module tb_ctrl_sequencer;

   typedef struct packed {
      logic       cv;
      logic       rd;
      logic       br;
      logic       m2r;
      logic       mw;
      logic       src;
      logic       rw;
      logic [2:0] op;
      logic       ill;
      logic       rdy;
   } out_t;

   typedef struct packed {
      logic       v;
      logic [3:0] op;
      logic       st;
      logic       fl;
      out_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, instr_valid, stall, flush;
   logic [3:0] instr;

   logic       cv0, rd0, br0, m2r0, mw0, src0, rw0, ill0, rdy0;
   logic [2:0] aluop0;
   logic       cv1, rd1, br1, m2r1, mw1, src1, rw1, ill1, rdy1;
   logic [2:0] aluop1;
   out_t       act0, act1;

   int   total = 0;
   int   bad   = 0;
   out_t exp_q[$];
   vec_t tbl[$];
   logic raw_cv = 1'b0;
   int   exp_retired = 0;
   int   exp_stalls  = 0;

   always #5 clk = ~clk;

`ifdef CTRL_SEQ_PERF_EN
   logic [31:0] ret0, stc0, ret1, stc1;
`endif

   ctrl_sequencer #(.MCODEBITS(4), .OPWIDTH(3), .MEM_LAT(3), .BR_BUBBLES(2)) u_dut0 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(rdy0), .stall(stall), .flush(flush), .ctrl_valid(cv0),
      .RegDst(rd0), .Branch(br0), .MemtoReg(m2r0), .MemWrite(mw0), .ALUSrc(src0),
      .RegWrite(rw0), .ALUOp(aluop0), .illegal(ill0)
`ifdef CTRL_SEQ_PERF_EN
      , .retired(ret0), .stall_cycles(stc0)
`endif
   );

   ctrl_sequencer #(.MCODEBITS(4), .OPWIDTH(3), .MEM_LAT(1), .BR_BUBBLES(0)) u_dut1 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(rdy1), .stall(stall), .flush(flush), .ctrl_valid(cv1),
      .RegDst(rd1), .Branch(br1), .MemtoReg(m2r1), .MemWrite(mw1), .ALUSrc(src1),
      .RegWrite(rw1), .ALUOp(aluop1), .illegal(ill1)
`ifdef CTRL_SEQ_PERF_EN
      , .retired(ret1), .stall_cycles(stc1)
`endif
   );

   assign act0 = {cv0, rd0, br0, m2r0, mw0, src0, rw0, aluop0, ill0, rdy0};
   assign act1 = {cv1, rd1, br1, m2r1, mw1, src1, rw1, aluop1, ill1, rdy1};

   function automatic out_t ex(input logic cv, br, m2r, mw, src, rw,
                               input logic [2:0] op, input logic ill, rdy);
      return {cv, 1'b0, br, m2r, mw, src, rw, op, ill, rdy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic v, input logic [3:0] op, input logic st,
                               input logic fl, input out_t e);
      tbl.push_back({v, op, st, fl, e});
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input logic v, input logic [3:0] op, input logic st, input logic fl,
                       input out_t e, input string name);
      out_t want;
      @(negedge clk);
      instr_valid = v; instr = op; stall = st; flush = fl;
      exp_q.push_back(e);
      if (raw_cv && !st) exp_retired++;
      if (st) exp_stalls++;
      if (!(st && !fl)) raw_cv = e.cv;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      check(name, 32'(act0), 32'(want));
   endtask

   task automatic drive1(input logic v, input logic [3:0] op, input out_t e, input string name);
      @(negedge clk);
      instr_valid = v; instr = op; stall = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      check(name, 32'(act1), 32'(e));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      raw_cv = 1'b0;
      exp_retired = 0;
      exp_stalls  = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      out_t nop1, nop0, ld, ld_fin, ill, store, add_o;
      nop1   = ex(0, 0, 0, 0, 0, 0, 3'b111, 0, 1);
      nop0   = ex(0, 0, 0, 0, 0, 0, 3'b111, 0, 0);
      ld     = ex(0, 0, 1, 0, 0, 0, 3'b111, 0, 0);
      ld_fin = ex(1, 0, 1, 0, 0, 1, 3'b111, 0, 0);
      ill    = ex(0, 0, 0, 0, 0, 0, 3'b111, 1, 0);
      store  = ex(1, 0, 0, 1, 0, 0, 3'b111, 0, 1);
      add_o  = ex(1, 0, 0, 0, 0, 1, 3'b000, 0, 1);

      // v, op, stall, flush, expected outputs after the edge (inputs still held)
      add(1, 4'd0, 0, 0, add_o);
      add(1, 4'd2, 0, 0, ex(1, 0, 0, 0, 0, 1, 3'b010, 0, 1));
      add(1, 4'd5, 0, 0, ex(1, 0, 0, 0, 0, 1, 3'b111, 0, 1));
      add(1, 4'd1, 0, 0, ex(1, 0, 0, 0, 0, 1, 3'b001, 0, 1));
      add(1, 4'd7, 0, 0, ex(1, 0, 0, 0, 1, 1, 3'b110, 0, 1));
      add(1, 4'd4, 0, 0, store);
      add(0, 4'd0, 0, 0, nop1);
      add(1, 4'd3, 0, 0, ld);
      add(1, 4'd0, 0, 0, ld);
      add(0, 4'd0, 0, 0, ld_fin);
      add(1, 4'd6, 0, 0, nop1);
      add(1, 4'd6, 0, 0, ex(1, 1, 0, 0, 0, 0, 3'b011, 0, 0));
      add(1, 4'd0, 0, 0, nop0);
      add(1, 4'd0, 0, 0, nop0);
      add(1, 4'd0, 0, 0, nop1);
      add(1, 4'd0, 0, 0, add_o);
      add(1, 4'd3, 0, 0, ld);
      add(0, 4'd0, 1, 0, ld);
      add(0, 4'd0, 1, 0, ld);
      add(0, 4'd0, 0, 0, ld);
      add(0, 4'd0, 0, 0, ld_fin);
      add(0, 4'd0, 0, 0, nop1);
      add(1, 4'd0, 1, 0, nop0);
      add(1, 4'd3, 0, 0, ld);
      add(0, 4'd0, 1, 1, nop0);
      add(0, 4'd0, 0, 0, nop1);
      add(0, 4'd0, 0, 0, nop1);
      add(1, 4'd0, 0, 1, nop0);
      add(0, 4'd0, 0, 0, nop1);

      reset = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dut0", 32'(act0), 32'(nop1));
      check("rst_dut1", 32'(act1), 32'(nop1));
`ifdef CTRL_SEQ_PERF_EN
      check("rst_retired", ret0, 32'd0);
      check("rst_stalls", stc0, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      // Single-cycle load and zero-bubble branch on the second instance.
      drive1(1, 4'd3, ex(1, 0, 1, 0, 0, 1, 3'b111, 0, 0), "d1_load_lat1");
      drive1(1, 4'd6, nop1, "d1_load_done");
      drive1(1, 4'd6, ex(1, 1, 0, 0, 0, 0, 3'b011, 0, 1), "d1_bne_nobubble");
      drive1(1, 4'd0, add_o, "d1_after_bne");

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].op, tbl[i].st, tbl[i].fl, tbl[i].e, $sformatf("vec%0d", i));
      end

      // A stalled store is masked, then shows again as soon as stall drops.
      step(1, 4'd4, 0, 0, store, "st_issue");
      step(0, 4'd0, 1, 0, nop0, "st_masked");
      stall = 1'b0;
      #1;
      check("st_restore", 32'(act0), 32'(store));
      step(0, 4'd0, 0, 0, nop1, "st_after");
`ifdef CTRL_SEQ_PERF_EN
      check("perf_retired", ret0, 32'(exp_retired));
      check("perf_stalls", stc0, 32'(exp_stalls));
`endif

      step(1, 4'd10, 0, 0, ill, "ill_set");
      step(1, 4'd0, 0, 0, ill, "ill_stuck");
      step(0, 4'd0, 0, 1, ill, "ill_flush");
      step(1, 4'd5, 0, 0, ill, "ill_still");
`ifdef CTRL_SEQ_PERF_EN
      check("perf_retired_ill", ret0, 32'(exp_retired));
`endif

      do_reset();
      #1;
      check("rst_clears_ill", 32'(act0), 32'(nop1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
